// File: rtl/regbus_pkg.sv
// regbus_pkg: shared widths, arbiter FSM encoding and register address map
// for the internal GPIO/UART register bus.
package regbus_pkg;

    localparam int REGBUS_ADDR_W = 5;
    localparam int REGBUS_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Register file map shared by the front-ends and the register file
    localparam logic [REGBUS_ADDR_W-1:0] GPA_OE    = 5'h00;
    localparam logic [REGBUS_ADDR_W-1:0] GPA_ODATA = 5'h01;
    localparam logic [REGBUS_ADDR_W-1:0] GPA_IDATA = 5'h02;
    localparam logic [REGBUS_ADDR_W-1:0] GPB_OE    = 5'h04;
    localparam logic [REGBUS_ADDR_W-1:0] GPB_ODATA = 5'h05;
    localparam logic [REGBUS_ADDR_W-1:0] GPB_IDATA = 5'h06;
    localparam logic [REGBUS_ADDR_W-1:0] GPC_OE    = 5'h08;
    localparam logic [REGBUS_ADDR_W-1:0] GPC_ODATA = 5'h09;
    localparam logic [REGBUS_ADDR_W-1:0] GPC_IDATA = 5'h0A;
    localparam logic [REGBUS_ADDR_W-1:0] UART_CTRL = 5'h17;
    localparam logic [REGBUS_ADDR_W-1:0] UART_DATA = 5'h18;
    localparam logic [REGBUS_ADDR_W-1:0] UART_STAT = 5'h19;
    localparam logic [REGBUS_ADDR_W-1:0] GPZ_IDATA = 5'h1E;

endpackage

// File: rtl/regbus_arbiter_if.sv
// regbus_arbiter_if: requester handshake plus register-file strobe signals around regbus_arbiter.
interface regbus_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = regbus_pkg::REGBUS_ADDR_W,
    parameter int DATA_W = regbus_pkg::REGBUS_DATA_W
);

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   bus_cs;
    logic                   bus_we;
    logic [ADDR_W-1:0]      bus_addr;
    logic [DATA_W-1:0]      bus_wdata;
    logic [DATA_W-1:0]      bus_rdata;

    modport slave (
        input  req, we, addr, wdata, bus_rdata,
        output gnt, done, rdata, busy, bus_cs, bus_we, bus_addr, bus_wdata
    );

    modport master (
        output req, we, addr, wdata, bus_rdata,
        input  gnt, done, rdata, busy, bus_cs, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/regbus_arbiter_rr_picker.sv
// rr_picker: combinational one-hot winner select, round robin after rr_ptr,
// or lowest-index-wins when built with REGBUS_FIXED_PRIO_EN.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx,
    output logic            any
);

    assign any = |req;
    assign win = any ? NREQ'(1) << win_idx : '0;

`ifdef REGBUS_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[k]) win_idx = PW'(k);
    end
`else
    logic [PW-1:0] idx;
    // Descending scan so the candidate nearest rr_ptr+1 is written last and wins
    always_comb begin
        win_idx = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) win_idx = idx;
        end
    end
`endif

endmodule

// File: rtl/regbus_arbiter.sv
// regbus_arbiter: arbitrates the GPIO register bus among NREQ requesters with a fixed read latency.
// Define REGBUS_FIXED_PRIO_EN for lowest-index priority instead of round robin.
module regbus_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = regbus_pkg::REGBUS_ADDR_W,
    parameter int DATA_W = regbus_pkg::REGBUS_DATA_W,
    parameter int RD_LAT = 1
) (
    input logic             osc_clk,
    input logic             rst_n,
    regbus_arbiter_if.slave bus
);

    import regbus_pkg::*;

    localparam int PW = $clog2(NREQ);

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     cur;
    logic [PW-1:0]     win_idx;
    logic [NREQ-1:0]   win;
    logic              any;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_a  [NREQ];
    logic [DATA_W-1:0] wdata_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = bus.addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = bus.wdata[i*DATA_W +: DATA_W];
    end

    rr_picker #(.NREQ(NREQ)) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    // Requester fields are latched at selection so later changes cannot disturb the access
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= PW'(NREQ - 1);
            cur           <= '0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.bus_cs    <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
        end else begin
            bus.gnt    <= '0;
            bus.done   <= '0;
            bus.bus_cs <= 1'b0;
            case (state)
                ST_IDLE: if (any) begin
                    state         <= ST_ISSUE;
                    cur           <= win_idx;
`ifndef REGBUS_FIXED_PRIO_EN
                    rr_ptr        <= win_idx;
`endif
                    bus.gnt       <= win;
                    bus.busy      <= 1'b1;
                    bus.bus_cs    <= 1'b1;
                    bus.bus_we    <= bus.we[win_idx];
                    bus.bus_addr  <= addr_a[win_idx];
                    bus.bus_wdata <= wdata_a[win_idx];
                end
                ST_ISSUE: if (bus.bus_we) begin
                    state    <= ST_DONE;
                    bus.done <= NREQ'(1) << cur;
                end else begin
                    state <= ST_WAIT;
                    cnt   <= 2'(RD_LAT - 1);
                end
                ST_WAIT: if (cnt == 2'd0) begin
                    state     <= ST_DONE;
                    bus.rdata <= bus.bus_rdata;
                    bus.done  <= NREQ'(1) << cur;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
Arbitrates the internal 5-bit-address / 8-bit-data GPIO register bus among NREQ requesters, such as the SPI frame decoder and a UART command parser.
- Accepts one transaction at a time using round-robin selection.
- Drives a single-cycle register-file strobe.
- Waits a fixed read latency, then returns completion and read data to the winner.
- Sits between the protocol front-ends and the GPIO/UART register file.

Parameters:
NREQ, 2, number of requesters (2..8).
ADDR_W, 5, register address width.
DATA_W, 8, register data width.
RD_LAT, 1, cycles from bus_cs to valid bus_rdata (1..4).

Ports:
osc_clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
req  in  NREQ  per-requester transaction request; held until done.
we  in  NREQ  per-requester write(1)/read(0); stable while req high.
addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
wdata  in  NREQ*DATA_W  packed write data, same packing.
gnt  out  NREQ  one-hot, 1-cycle pulse: request captured.
done  out  NREQ  one-hot, 1-cycle pulse: transaction complete; rdata valid for reads.
rdata  out  DATA_W  read data, held until next read completes.
busy  out  1  high when state != IDLE.
bus_cs  out  1  1-cycle register-file access strobe.
bus_we  out  1  write qualifier for bus_cs.
bus_addr  out  ADDR_W  register address.
bus_wdata  out  DATA_W  write data.
bus_rdata  in  DATA_W  register-file read data.

Behaviour:
- Reset values: gnt=0, done=0, rdata=0, busy=0, bus_cs=0, bus_we=0, bus_addr=0, bus_wdata=0; state=IDLE; rr_ptr=NREQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high at clock edge t, select the winner by searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - Latch the winner's we/addr/wdata into bus_we/bus_addr/bus_wdata.
  - At t+1: state=ISSUE, gnt[winner]=1, bus_cs=1, rr_ptr=winner.
- ISSUE (1 cycle):
  - bus_cs high, gnt pulse high.
  - Write: next state DONE.
  - Read: next state WAIT, with wait counter loaded with RD_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - When counter == 0, capture bus_rdata into rdata and go to DONE.
  - WAIT lasts exactly RD_LAT cycles.
- DONE (1 cycle): done[winner]=1, then IDLE.
- Latency from req edge t:
  - Write: gnt/bus_cs at t+1, done at t+2.
  - Read: gnt/bus_cs at t+1, done at t+2+RD_LAT.
  - Minimum write throughput: one transaction per 3 cycles.
- Requester contract:
  - Deassert req in the done cycle at the latest. A req still high in the first IDLE cycle is a new transaction.
  - Changing we/addr/wdata after gnt has no effect; values are latched.
- Req dropped after gnt: transaction still completes and done still pulses.
- Simultaneous requests: exactly one gnt; the others wait. Round robin bounds the wait to NREQ-1 transactions.
- Requests arriving while busy: not sampled until IDLE; no queuing beyond the req level.
- bus_addr/bus_we/bus_wdata hold their last values outside ISSUE.
- Writes leave rdata unchanged.
- Reset mid-operation: immediate return to reset values. No done is issued for the aborted transaction, and any register write not yet strobed is lost.

Optional Feature:
REGBUS_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index asserted req always wins and rr_ptr is unused (held at reset value).
- Undefined: round-robin as above.
- Latency, FSM and handshake are identical in both modes.

Decomposition:
- Shared package regbus_pkg:
  - ADDR_W/DATA_W defaults.
  - FSM state encoding constants (ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_DONE=2'd3).
  - Register address map constants used by front-ends and the register file (GPA_OE 'h00 … UART_DATA 'h18, UART_STAT 'h19, GPZ_IDATA 'h1E).
- Sub-module rr_picker:
  - Combinational NREQ-wide round-robin/priority selector.
  - Inputs req and rr_ptr; outputs one-hot winner plus any.
  - Holds the REGBUS_FIXED_PRIO_EN switch.

Test Plan:
- Reset then req[0]=1, we=1, addr=0x01, wdata=0xA5:
  - gnt[0] and bus_cs with bus_addr=0x01, bus_wdata=0xA5, bus_we=1 one cycle later.
  - done[0] the following cycle.
- RD_LAT=2, req[1] read addr=0x0A, bus_rdata=0x3C at the expected cycle: done[1] at t+4 with rdata=0x3C; busy high cycles t+1..t+4.
- req[0] and req[1] held continuously (re-asserted after each done), round-robin build:
  - Grants alternate 0,1,0,1 over 4 transactions.
  - With REGBUS_FIXED_PRIO_EN, all 4 go to requester 0.
- req[1] asserted during requester 0's WAIT: not granted until IDLE; gnt[1] exactly one cycle after done[0]+1.
- rst_n pulsed low during WAIT of a read:
  - All outputs return to 0 asynchronously; no done pulse.
  - After release, first grant goes to requester 0.
- req[0] dropped the cycle after gnt[0] (write to 0x0B, 0x01): bus_cs still issued once and done[0] still pulses.
